// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) round-robin arbiter in front of a
// single memory. One access is outstanding at a time: the grant cycle
// (IDLE) issues the memory command and the following cycle (RESP) returns
// the one-cycle response to the winner.
//
// Ports
//   clock, reset                 sole clock, async active-high reset
//   if_req/if_addr -> if_gnt     fetch request / grant
//   if_rvalid/if_rdata/if_err    fetch response
//   d_req/d_we/d_addr/d_wdata    data request (load or store)
//   d_gnt                        data grant
//   d_rvalid/d_rdata/d_err       data response (store: write acknowledge)
//   mem_pc_*                     memory instruction port
//   mem_read_*                   memory data read port
//   mem_write_*                  memory write port
module mem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_pc_enable,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_pc_value,
    output logic        mem_read_enable,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_value,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_value
);

    // 33-bit so MEM_WORDS*4 == 2^32 would still compare correctly
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
    // Where the response data comes from in RESP
    typedef enum logic [1:0] {SRC_ZERO = 2'd0, SRC_PC = 2'd1, SRC_READ = 2'd2} rsrc_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1: data requester granted last
    logic        resp_if_q, resp_if_d;
    logic        resp_d_q, resp_d_d;
    logic        resp_err_q, resp_err_d;
    rsrc_t       rsrc_q, rsrc_d;

    logic        pick_data, pick_fetch, grant, legal;
    logic        pc_en, rd_en, wr_en;
    logic [31:0] sel_addr, resp_data;

    // Arbitration: data wins if it is the only requester, or on a tie when
    // fetch was granted last.
    always_comb begin
        pick_data  = d_req & (~if_req | ~last_data_q);
        pick_fetch = if_req & ~pick_data;
        grant      = ~reset & (state_q == IDLE) & (if_req | d_req);
        sel_addr   = pick_data ? d_addr : if_addr;
        legal      = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < MEM_BYTES);
        pc_en      = grant & pick_fetch & legal;
        rd_en      = grant & pick_data & ~d_we & legal;
        wr_en      = grant & pick_data & d_we & legal;
    end

    assign if_gnt            = grant & pick_fetch;
    assign d_gnt             = grant & pick_data;
    assign mem_pc_enable     = pc_en;
    assign mem_pc            = pc_en ? if_addr : 32'd0;
    assign mem_read_enable   = rd_en;
    assign mem_read_address  = rd_en ? d_addr : 32'd0;
    assign mem_write_enable  = wr_en;
    assign mem_write_address = wr_en ? d_addr : 32'd0;
    assign mem_write_value   = wr_en ? d_wdata : 32'd0;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        resp_if_d   = 1'b0;
        resp_d_d    = 1'b0;
        resp_err_d  = 1'b0;
        rsrc_d      = SRC_ZERO;
        if (state_q == RESP) begin
            state_d = IDLE;
        end else if (grant) begin
            state_d     = RESP;
            last_data_d = pick_data;
            resp_if_d   = pick_fetch;
            resp_d_d    = pick_data;
            resp_err_d  = ~legal;
            // Illegal accesses and stores answer with zero data
            if (legal && pick_fetch)
                rsrc_d = SRC_PC;
            else if (legal && !d_we)
                rsrc_d = SRC_READ;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;    // fetch wins the first tie
            resp_if_q   <= 1'b0;
            resp_d_q    <= 1'b0;
            resp_err_q  <= 1'b0;
            rsrc_q      <= SRC_ZERO;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            resp_if_q   <= resp_if_d;
            resp_d_q    <= resp_d_d;
            resp_err_q  <= resp_err_d;
            rsrc_q      <= rsrc_d;
        end
    end

    // Memory returns read data one cycle after the enable, i.e. in RESP
    always_comb begin
        case (rsrc_q)
            SRC_PC:   resp_data = mem_pc_value;
            SRC_READ: resp_data = mem_read_value;
            default:  resp_data = 32'd0;
        endcase
    end

    assign if_rvalid = resp_if_q;
    assign if_err    = resp_if_q & resp_err_q;
    assign if_rdata  = resp_if_q ? resp_data : 32'd0;
    assign d_rvalid  = resp_d_q;
    assign d_err     = resp_d_q & resp_err_q;
    assign d_rdata   = resp_d_q ? resp_data : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MEM_WORDS = 1024;
    localparam int MEM_BYTES = MEM_WORDS * 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_pc_enable, mem_read_enable, mem_write_enable;
    logic [31:0] mem_pc, mem_read_address, mem_write_address, mem_write_value;
    logic [31:0] mem_pc_value = 32'd0;
    logic [31:0] mem_read_value = 32'd0;

    mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_pc_enable(mem_pc_enable), .mem_pc(mem_pc), .mem_pc_value(mem_pc_value),
        .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
        .mem_read_value(mem_read_value),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_value(mem_write_value)
    );

    always #5 clock = ~clock;

    // Attached memory: synchronous read, one cycle latency, no reset
    logic [31:0] mem [MEM_WORDS];
    always @(posedge clock) begin
        if (mem_pc_enable && mem_pc < 32'(MEM_BYTES))
            mem_pc_value <= mem[mem_pc[11:2]];
        if (mem_read_enable && mem_read_address < 32'(MEM_BYTES))
            mem_read_value <= mem[mem_read_address[11:2]];
        if (mem_write_enable && mem_write_address < 32'(MEM_BYTES))
            mem[mem_write_address[11:2]] <= mem_write_value;
    end

    // Reference model state
    logic [31:0] ref_mem [MEM_WORDS];
    bit          m_busy;          // an access is awaiting its response
    bit          m_last_data;     // last winner was the data requester
    bit          m_rv_if, m_rv_d, m_err;
    logic [31:0] m_rdata;
    bit          hold_reqs = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // Values observed in the last tick, for directed checks
    logic        obs_if_gnt, obs_d_gnt, obs_pc_en, obs_wr_en, obs_rd_en;
    logic        obs_if_rvalid, obs_d_rvalid, obs_if_err, obs_d_err;
    logic [31:0] obs_pc, obs_wr_addr, obs_if_rdata, obs_d_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the model at the negedge,
    // advance the model, then release the request of whoever was granted.
    task automatic tick();
        logic        e_ig, e_dg, e_pc_en, e_rd_en, e_wr_en;
        logic [31:0] e_pc, e_rd_a, e_wr_a, e_wr_v;
        logic        e_irv, e_drv, e_ierr, e_derr;
        logic [31:0] e_ird, e_drd, a;
        bit          win_fetch, win_data, ok;
        @(negedge clock);
        {e_ig, e_dg, e_pc_en, e_rd_en, e_wr_en} = '0;
        {e_pc, e_rd_a, e_wr_a, e_wr_v, e_ird, e_drd} = '0;
        {e_irv, e_drv, e_ierr, e_derr} = '0;
        win_fetch = 0;
        win_data  = 0;
        ok        = 0;
        a         = 32'd0;
        if (reset) begin
            m_busy = 0; m_last_data = 1; m_rv_if = 0; m_rv_d = 0;
        end else begin
            if (m_rv_if) begin e_irv = 1; e_ierr = m_err; e_ird = m_rdata; end
            if (m_rv_d)  begin e_drv = 1; e_derr = m_err; e_drd = m_rdata; end
            if (!m_busy) begin
                if (if_req && d_req) begin
                    win_data  = !m_last_data ? 1'b1 : 1'b0;
                    win_fetch = !win_data;
                end else begin
                    win_fetch = if_req;
                    win_data  = d_req;
                end
            end
            if (win_fetch) a = if_addr;
            if (win_data)  a = d_addr;
            ok = (a % 4 == 0) && (a < 32'(MEM_BYTES));
            e_ig = win_fetch;
            e_dg = win_data;
            if (win_fetch && ok) begin e_pc_en = 1; e_pc = a; end
            if (win_data && ok && !d_we) begin e_rd_en = 1; e_rd_a = a; end
            if (win_data && ok && d_we) begin e_wr_en = 1; e_wr_a = a; e_wr_v = d_wdata; end
        end
        check_val("if_gnt", 32'(if_gnt), 32'(e_ig));
        check_val("d_gnt", 32'(d_gnt), 32'(e_dg));
        check_val("pc_en", 32'(mem_pc_enable), 32'(e_pc_en));
        check_val("pc", mem_pc, e_pc);
        check_val("rd_en", 32'(mem_read_enable), 32'(e_rd_en));
        check_val("rd_addr", mem_read_address, e_rd_a);
        check_val("wr_en", 32'(mem_write_enable), 32'(e_wr_en));
        check_val("wr_addr", mem_write_address, e_wr_a);
        check_val("wr_val", mem_write_value, e_wr_v);
        check_val("if_rvalid", 32'(if_rvalid), 32'(e_irv));
        check_val("if_rdata", if_rdata, e_ird);
        check_val("if_err", 32'(if_err), 32'(e_ierr));
        check_val("d_rvalid", 32'(d_rvalid), 32'(e_drv));
        check_val("d_rdata", d_rdata, e_drd);
        check_val("d_err", 32'(d_err), 32'(e_derr));
        {obs_if_gnt, obs_d_gnt, obs_pc_en, obs_wr_en, obs_rd_en} =
            {if_gnt, d_gnt, mem_pc_enable, mem_write_enable, mem_read_enable};
        {obs_if_rvalid, obs_d_rvalid, obs_if_err, obs_d_err} = {if_rvalid, d_rvalid, if_err, d_err};
        obs_pc = mem_pc; obs_wr_addr = mem_write_address;
        obs_if_rdata = if_rdata; obs_d_rdata = d_rdata;
        // Advance the model
        if (!reset) begin
            m_rv_if = 0; m_rv_d = 0; m_err = 0; m_rdata = 32'd0;
            if (m_busy) begin
                m_busy = 0;
            end else if (win_fetch || win_data) begin
                m_busy      = 1;
                m_last_data = win_data;
                m_rv_if     = win_fetch;
                m_rv_d      = win_data;
                m_err       = !ok;
                if (ok && win_fetch) m_rdata = ref_mem[a[11:2]];
                else if (ok && !d_we) m_rdata = ref_mem[a[11:2]];
                else if (ok) ref_mem[a[11:2]] = d_wdata;
            end
        end
        @(posedge clock);
        #1;
        if (!hold_reqs) begin
            if (win_fetch) if_req = 0;
            if (win_data)  d_req  = 0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        logic [31:0] v;
        case (r)
            0:       v = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            1:       v = 32'h1000 + (32'($urandom_range(0, 1000)) << 2);
            2:       v = ($urandom | 32'h8000_0000) & ~32'd3;
            3, 4, 5: v = 32'($urandom_range(0, 15)) << 2;
            default: v = 32'($urandom_range(0, 1023)) << 2;
        endcase
        return v;
    endfunction

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        // Reset: all outputs zero
        reset = 1;
        #1;
        tick();
        tick();
        reset = 0;

        // Idle for 5 cycles
        for (int i = 0; i < 5; i++) tick();

        // Both requesters held: fetch, data, fetch, data at cycles 0,2,4,6
        hold_reqs = 1;
        if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 0; d_addr = 32'h44;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val($sformatf("rr_if_gnt%0d", i), 32'(obs_if_gnt), (i % 4 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("rr_d_gnt%0d", i), 32'(obs_d_gnt), (i % 4 == 2) ? 32'd1 : 32'd0);
        end
        hold_reqs = 0;
        if_req = 0; d_req = 0;
        tick();

        // Single fetch of word 4
        if_req = 1; if_addr = 32'h10;
        tick();
        check_val("f_gnt", 32'(obs_if_gnt), 32'd1);
        check_val("f_pc_en", 32'(obs_pc_en), 32'd1);
        check_val("f_pc", obs_pc, 32'h10);
        tick();
        check_val("f_rvalid", 32'(obs_if_rvalid), 32'd1);
        check_val("f_rdata", obs_if_rdata, 32'hDEADBEEF);

        // Store then load
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
        tick();
        check_val("st_wr_en", 32'(obs_wr_en), 32'd1);
        check_val("st_wr_addr", obs_wr_addr, 32'h20);
        tick();
        check_val("st_ack", 32'(obs_d_rvalid), 32'd1);
        check_val("st_rdata", obs_d_rdata, 32'd0);
        d_req = 1; d_we = 0; d_addr = 32'h20;
        tick();
        tick();
        check_val("ld_rvalid", 32'(obs_d_rvalid), 32'd1);
        check_val("ld_rdata", obs_d_rdata, 32'h12345678);

        // Illegal accesses
        d_req = 1; d_we = 0; d_addr = 32'h1002;
        tick();
        check_val("ill_d_gnt", 32'(obs_d_gnt), 32'd1);
        check_val("ill_d_en", 32'({obs_pc_en, obs_rd_en, obs_wr_en}), 32'd0);
        tick();
        check_val("ill_d_err", 32'(obs_d_err), 32'd1);
        check_val("ill_d_rdata", obs_d_rdata, 32'd0);
        if_req = 1; if_addr = 32'h1000;
        tick();
        check_val("ill_if_gnt", 32'(obs_if_gnt), 32'd1);
        check_val("ill_if_en", 32'({obs_pc_en, obs_rd_en, obs_wr_en}), 32'd0);
        tick();
        check_val("ill_if_err", 32'(obs_if_err), 32'd1);
        check_val("ill_if_rdata", obs_if_rdata, 32'd0);

        // Reset during RESP of a load
        d_req = 1; d_we = 0; d_addr = 32'h8;
        tick();
        check_val("rr_ld_gnt", 32'(obs_d_gnt), 32'd1);
        reset = 1;
        d_req = 1; d_addr = 32'hC;
        tick();
        check_val("rr_no_rvalid", 32'(obs_d_rvalid), 32'd0);
        reset = 0;
        tick();
        check_val("rr_first_gnt", 32'(obs_d_gnt), 32'd1);
        tick();
        check_val("rr_rdata", obs_d_rdata, ref_mem[3]);

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            if (!if_req) begin
                if_addr = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    if_req = 1; if_addr = rand_addr();
                end
            end
            if (!d_req) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1; d_addr = rand_addr();
                end
            end
            if (i % 113 == 57) reset = 1;
            tick();
            reset = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
